stopwatch_ctrl_fsm: RTL and testbench
=====================================

// Module: stopwatch_ctrl_fsm
// PURPOSE
//   Mode sequencer for the stopwatch counting datapath. Takes debounced pause/sel/adj
//   levels and produces the datapath's timing and control: the 1 Hz count tick while
//   running, the minute/second increment pulses in adjust mode, and a blink mask for
//   the display controller. Replaces the free-standing start/stop arbiter, with prescalers.
// PARAMETERS
//   ONE_HZ_DIV  100_000_000  clk cycles per count tick (>=2)
//   ADJ_DIV     50_000_000   clk cycles per adjust increment / blink half-period (>=2)
// PORTS
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high; clears all state
//   pause       in   1  debounced pause button level; rising edge = press
//   sel         in   1  debounced select: 0 = seconds, 1 = minutes
//   adj         in   1  debounced adjust switch level
//   count_en    out  1  1-cycle pulse: advance seconds by one (RUN only)
//   inc_sec     out  1  1-cycle pulse: add one to seconds (ADJUST, sel=0)
//   inc_min     out  1  1-cycle pulse: add one to minutes (ADJUST, sel=1)
//   blink_mask  out  4  per-anode blank request, [3:2]=minutes, [1:0]=seconds
//   state       out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 ADJUST
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset values: state=IDLE, count_en=inc_sec=inc_min=0, blink_mask=0, both
//     prescalers=0, blink phase=0, pause_q=1 (button held through reset is no press).
//   press = pause & ~pause_q (combinational); pause_q <= pause each cycle.
//   FSM, evaluated each rising clk edge, priority top-down:
//     adj=1 (any state)      -> ADJUST
//     ADJUST and adj=0       -> PAUSED
//     IDLE  and press        -> RUN
//     RUN   and press        -> PAUSED
//     PAUSED and press       -> RUN
//     otherwise hold. press ignored in ADJUST and on the cycle adj forces ADJUST.
//   State latency: press seen at edge N -> state output changes after edge N.
//   1 Hz prescaler (width clog2(ONE_HZ_DIV)):
//     RUN: increments; at ONE_HZ_DIV-1 wraps to 0 and count_en=1 for that cycle.
//     PAUSED: holds (sub-second phase preserved across pause/resume).
//     IDLE, ADJUST: cleared to 0.
//     First tick after IDLE->RUN arrives ONE_HZ_DIV cycles after entering RUN.
//   Adjust prescaler (width clog2(ADJ_DIV)):
//     ADJUST: increments; at ADJ_DIV-1 wraps to 0, toggles blink phase and
//       pulses inc_sec (sel=0) or inc_min (sel=1), sel sampled that same cycle.
//     Other states: cleared to 0, blink phase cleared to 0.
//     First increment ADJ_DIV cycles after entering ADJUST; sel change does not
//       restart the prescaler.
//   blink_mask (registered): ADJUST & phase=1 -> sel ? 4'b1100 : 4'b0011; else 4'b0000.
//   Outputs count_en/inc_sec/inc_min are registered, mutually exclusive, never
//     asserted for more than one consecutive cycle.
//   Reset mid-operation: all outputs drop in the same cycle reset asserts.
//   Leaving ADJUST never emits a stray count_en; PAUSED->RUN resumes prescaler phase.
// TESTING (bench uses ONE_HZ_DIV=10, ADJ_DIV=4)
//   Reset release, press pause once -> state=01; count_en pulses every 10 cycles,
//     first pulse 10 cycles after state=01.
//   RUN 7 cycles past a tick, press -> state=10, no count_en; press again ->
//     state=01, next count_en exactly 3 cycles later.
//   adj=1 while RUN, sel=0 -> state=11, count_en silent, inc_sec every 4 cycles,
//     blink_mask alternates 0011/0000 every 4 cycles; sel=1 -> inc_min, mask 1100.
//   adj 1->0 -> state=10, blink_mask=0, no inc pulses; pause presses during
//     ADJUST produce no state change.
//   pause held high across reset release -> no press, state stays 00.
//   reset asserted mid-RUN and mid-ADJUST -> all outputs 0 and state=00 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch mode sequencer: IDLE/RUN/PAUSED/ADJUST FSM with the 1 Hz count prescaler,
// the adjust-rate prescaler and the display blink mask.
module stopwatch_ctrl_fsm #(
  parameter int unsigned ONE_HZ_DIV = 100_000_000,
  parameter int unsigned ADJ_DIV    = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       sel,
  input  logic       adj,
  output logic       count_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic [3:0] blink_mask,
  output logic [1:0] state
);

  localparam int unsigned HzW  = $clog2(ONE_HZ_DIV);
  localparam int unsigned AdjW = $clog2(ADJ_DIV);
  localparam logic [HzW-1:0]  HzLast  = HzW'(ONE_HZ_DIV - 1);
  localparam logic [AdjW-1:0] AdjLast = AdjW'(ADJ_DIV - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10,
    StAdjust = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [HzW-1:0]  hz_q, hz_d;
  logic [AdjW-1:0] adj_cnt_q, adj_cnt_d;
  logic            phase_q, phase_d;
  logic            pause_q;
  logic            count_en_q, count_en_d;
  logic            inc_sec_q, inc_sec_d;
  logic            inc_min_q, inc_min_d;
  logic [3:0]      mask_q, mask_d;
  logic            press;

  assign press = pause & ~pause_q;

  always_comb begin
    state_d    = state_q;
    hz_d       = hz_q;
    adj_cnt_d  = adj_cnt_q;
    phase_d    = phase_q;
    count_en_d = 1'b0;
    inc_sec_d  = 1'b0;
    inc_min_d  = 1'b0;
    mask_d     = 4'b0000;

    // adj overrides everything, so a press on the entry cycle is dropped.
    if (adj) begin
      state_d = StAdjust;
    end else begin
      unique case (state_q)
        StIdle:   if (press) state_d = StRun;
        StRun:    if (press) state_d = StPaused;
        StPaused: if (press) state_d = StRun;
        StAdjust: state_d = StPaused;
        default:  state_d = StIdle;
      endcase
    end

    // PAUSED holds the prescaler so a resume keeps the sub-second phase.
    unique case (state_q)
      StRun: begin
        if (hz_q == HzLast) begin
          hz_d       = '0;
          count_en_d = 1'b1;
        end else begin
          hz_d = hz_q + 1'b1;
        end
      end
      StPaused: hz_d = hz_q;
      default:  hz_d = '0;
    endcase

    if (state_q == StAdjust) begin
      if (adj_cnt_q == AdjLast) begin
        adj_cnt_d = '0;
        phase_d   = ~phase_q;
        inc_sec_d = ~sel;
        inc_min_d = sel;
      end else begin
        adj_cnt_d = adj_cnt_q + 1'b1;
      end
    end else begin
      adj_cnt_d = '0;
      phase_d   = 1'b0;
    end

    if (state_d == StAdjust && phase_d) begin
      mask_d = sel ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hz_q       <= '0;
      adj_cnt_q  <= '0;
      phase_q    <= 1'b0;
      pause_q    <= 1'b1;
      count_en_q <= 1'b0;
      inc_sec_q  <= 1'b0;
      inc_min_q  <= 1'b0;
      mask_q     <= 4'b0000;
    end else begin
      state_q    <= state_d;
      hz_q       <= hz_d;
      adj_cnt_q  <= adj_cnt_d;
      phase_q    <= phase_d;
      pause_q    <= pause;
      count_en_q <= count_en_d;
      inc_sec_q  <= inc_sec_d;
      inc_min_q  <= inc_min_d;
      mask_q     <= mask_d;
    end
  end

  assign count_en   = count_en_q;
  assign inc_sec    = inc_sec_q;
  assign inc_min    = inc_min_q;
  assign blink_mask = mask_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: cycle model of the mode/timing rules compared every cycle,
// plus directed scenarios with hand-counted latencies.
module tb_stopwatch_ctrl_fsm;

  localparam int OneHz = 10;
  localparam int AdjN  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b1;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic       count_en, inc_sec, inc_min;
  logic [3:0] blink_mask;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl_fsm #(
    .ONE_HZ_DIV(OneHz),
    .ADJ_DIV   (AdjN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .sel       (sel),
    .adj       (adj),
    .count_en  (count_en),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .blink_mask(blink_mask),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode number 0..3, cycles spent running since last tick, cycles in adjust.
  int         m_state, m_sub, m_adjc;
  logic       m_phase, m_prev;
  logic       e_cnt, e_is, e_im;
  logic [3:0] e_mask;

  always @(posedge clk or posedge reset) begin : model
    int   ns, sub, ac;
    logic ph, pr, ce, is_, im;
    if (reset) begin
      m_state <= 0; m_sub <= 0; m_adjc <= 0; m_phase <= 1'b0; m_prev <= 1'b1;
      e_cnt <= 1'b0; e_is <= 1'b0; e_im <= 1'b0; e_mask <= 4'h0;
    end else begin
      pr = pause && !m_prev;
      sub = m_sub; ac = m_adjc; ph = m_phase; ce = 1'b0; is_ = 1'b0; im = 1'b0;
      if (m_state == 1) begin
        sub = sub + 1;
        if (sub == OneHz) begin sub = 0; ce = 1'b1; end
      end else if (m_state != 2) begin
        sub = 0;
      end
      if (m_state == 3) begin
        ac = ac + 1;
        if (ac == AdjN) begin
          ac = 0; ph = !ph;
          if (sel) im = 1'b1; else is_ = 1'b1;
        end
      end else begin
        ac = 0; ph = 1'b0;
      end
      if (adj) ns = 3;
      else if (m_state == 3) ns = 2;
      else if (pr && m_state == 0) ns = 1;
      else if (pr && m_state == 1) ns = 2;
      else if (pr && m_state == 2) ns = 1;
      else ns = m_state;
      m_state <= ns; m_sub <= sub; m_adjc <= ac; m_phase <= ph; m_prev <= pause;
      e_cnt <= ce; e_is <= is_; e_im <= im;
      e_mask <= (ns == 3 && ph) ? (sel ? 4'hC : 4'h3) : 4'h0;
    end
  end

  always @(negedge clk) begin
    check("state", {2'b00, state}, 4'(m_state));
    check("count_en", {3'b000, count_en}, {3'b000, e_cnt});
    check("inc_sec", {3'b000, inc_sec}, {3'b000, e_is});
    check("inc_min", {3'b000, inc_min}, {3'b000, e_im});
    check("blink_mask", blink_mask, e_mask);
  end

  task automatic press_pause();
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
  endtask

  // Cycles until the chosen pulse (0 count_en, 1 inc_sec, 2 inc_min); bounded.
  task automatic wait_pulse(input int which, input string name, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 50) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? count_en : (which == 1) ? inc_sec : inc_min;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no pulse within %0d cycles", name, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state"}, {2'b00, state}, 4'h0);
    check({name, "_pulses"}, {1'b0, count_en, inc_sec, inc_min}, 4'h0);
    check({name, "_mask"}, blink_mask, 4'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    // pause held through reset release is not a press
    repeat (5) @(negedge clk);
    check("held_pause_state", {2'b00, state}, 4'h0);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_state", {2'b00, state}, 4'h0);

    press_pause();
    check("run_state", {2'b00, state}, 4'h1);
    wait_pulse(0, "first_tick", n);
    check("first_tick_latency", 4'(n), 4'd10);
    wait_pulse(0, "second_tick", n);
    check("tick_period", 4'(n), 4'd10);

    // press lands 7 cycles past the tick
    repeat (5) @(negedge clk);
    press_pause();
    check("paused_state", {2'b00, state}, 4'h2);
    repeat (6) @(negedge clk);
    check("paused_quiet", {3'b000, count_en}, 4'h0);
    press_pause();
    check("resume_state", {2'b00, state}, 4'h1);
    wait_pulse(0, "resume_tick", n);
    check("resume_latency", 4'(n), 4'd3);

    repeat (2) @(negedge clk);
    adj = 1'b1;
    sel = 1'b0;
    @(negedge clk);
    check("adjust_state", {2'b00, state}, 4'h3);
    wait_pulse(1, "inc_sec1", n);
    check("inc_sec_latency", 4'(n), 4'd4);
    check("mask_sec_on", blink_mask, 4'b0011);
    wait_pulse(1, "inc_sec2", n);
    check("inc_sec_period", 4'(n), 4'd4);
    check("mask_sec_off", blink_mask, 4'b0000);
    sel = 1'b1;
    wait_pulse(2, "inc_min", n);
    check("inc_min_period", 4'(n), 4'd4);
    check("mask_min_on", blink_mask, 4'b1100);
    press_pause();
    check("adjust_ignores_press", {2'b00, state}, 4'h3);
    adj = 1'b0;
    @(negedge clk);
    check("leave_adjust_state", {2'b00, state}, 4'h2);
    check("leave_adjust_mask", blink_mask, 4'h0);
    repeat (6) @(negedge clk);

    // reset mid-RUN
    press_pause();
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_run");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid-ADJUST with the mask lit
    adj = 1'b1;
    sel = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_reset_mask", blink_mask, 4'b1100);
    #2 reset = 1'b1;
    #1 check_all_zero("reset_adj");
    adj = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
